// File: rtl/jogo_seq_unidade_controle.sv
// Control unit for the sequence-memory game: shows the sequence, waits for
// presses, compares them, and tracks lives with an internal timer.
//
// state        | meaning
// inicial      | idle, datapath cleared, waiting for jogar
// preparacao   | new game: clear counters, reload lives
// nova_seq     | round passed: advance L, rewind E
// espera       | waiting for a press, timeout running
// registra     | latch the press into R
// comparacao   | compare R against memory[E]
// proximo      | advance E within the round
// mostra       | display memory[E] for MOSTRA_CICLOS cycles
// mostra_prox  | advance E during the display phase
// fim_mostra   | display done, rewind E for the player
// perde_vida   | error or timeout with lives left: lose one, replay round
// fim_acerto   | game won
// fim_erro     | game lost by a wrong press
// fim_timeout  | game lost by timeout
module jogo_seq_unidade_controle #(
   parameter int TIMEOUT       = 5000,
   parameter int MOSTRA_CICLOS = 500,
   parameter int VIDAS         = 3,
   parameter int VW            = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          jogar,
   input  logic          jogada,
   input  logic          igualE,
   input  logic          igualL,
   input  logic          fimL,
   output logic          zeraE,
   output logic          contaE,
   output logic          zeraL,
   output logic          contaL,
   output logic          zeraR,
   output logic          registraR,
   output logic          exibe,
   output logic          acertou,
   output logic          errou,
   output logic          deu_timeout,
   output logic          pronto,
   output logic [VW-1:0] vidas,
   output logic [3:0]    db_estado
);

   localparam int TMAX = (TIMEOUT > MOSTRA_CICLOS) ? TIMEOUT : MOSTRA_CICLOS;
   localparam int TW   = $clog2(TMAX);

   typedef enum logic [3:0] {
      inicial     = 4'h0,
      preparacao  = 4'h1,
      nova_seq    = 4'h2,
      espera      = 4'h3,
      registra    = 4'h4,
      comparacao  = 4'h5,
      proximo     = 4'h6,
      mostra      = 4'h7,
      mostra_prox = 4'h8,
      fim_mostra  = 4'h9,
      fim_acerto  = 4'hA,
      perde_vida  = 4'hB,
      fim_timeout = 4'hD,
      fim_erro    = 4'hE
   } estado_t;

   estado_t       estado, estado_next;
   logic [TW-1:0] timer, timer_next;
   logic [VW-1:0] vidas_next;
   logic          tem_vida;
   logic          fim_mostra_tempo;
   logic          fim_espera_tempo;

   assign tem_vida         = (vidas > VW'(1));
   assign fim_mostra_tempo = (timer == TW'(MOSTRA_CICLOS - 1));
   assign fim_espera_tempo = (timer == TW'(TIMEOUT - 1));

   // State, timer and lives registers
   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= inicial;
         timer  <= '0;
         vidas  <= VW'(VIDAS);
      end else begin
         estado <= estado_next;
         timer  <= timer_next;
         vidas  <= vidas_next;
      end
   end

   // Next-state, timer/lives update and Moore output decode
   always_comb begin
      estado_next = estado;
      vidas_next  = vidas;
      zeraE       = 1'b0;
      contaE      = 1'b0;
      zeraL       = 1'b0;
      contaL      = 1'b0;
      zeraR       = 1'b0;
      registraR   = 1'b0;
      exibe       = 1'b0;
      acertou     = 1'b0;
      errou       = 1'b0;
      deu_timeout = 1'b0;
      pronto      = 1'b0;
      db_estado   = estado;

      case (estado)
         inicial: begin
            zeraE = 1'b1;
            zeraL = 1'b1;
            zeraR = 1'b1;
            if (jogar) estado_next = preparacao;
         end
         preparacao: begin
            zeraE       = 1'b1;
            zeraL       = 1'b1;
            zeraR       = 1'b1;
            vidas_next  = VW'(VIDAS);
            estado_next = mostra;
         end
         nova_seq: begin
            zeraE       = 1'b1;
            contaL      = 1'b1;
            estado_next = mostra;
         end
         espera: begin
            // A press on the last cycle still counts as a valid press
            if (jogada)                estado_next = registra;
            else if (fim_espera_tempo) estado_next = tem_vida ? perde_vida : fim_timeout;
         end
         registra: begin
            registraR   = 1'b1;
            estado_next = comparacao;
         end
         comparacao: begin
            if (!igualE)      estado_next = tem_vida ? perde_vida : fim_erro;
            else if (!igualL) estado_next = proximo;
            else              estado_next = fimL ? fim_acerto : nova_seq;
         end
         proximo: begin
            contaE      = 1'b1;
            estado_next = espera;
         end
         mostra: begin
            exibe = 1'b1;
            if (fim_mostra_tempo) estado_next = igualL ? fim_mostra : mostra_prox;
         end
         mostra_prox: begin
            contaE      = 1'b1;
            estado_next = mostra;
         end
         fim_mostra: begin
            zeraE       = 1'b1;
            estado_next = espera;
         end
         perde_vida: begin
            zeraE       = 1'b1;
            vidas_next  = tem_vida ? (vidas - VW'(1)) : vidas;
            estado_next = mostra;
         end
         fim_acerto: begin
            acertou = 1'b1;
            pronto  = 1'b1;
            if (jogar) estado_next = preparacao;
         end
         fim_erro: begin
            errou  = 1'b1;
            pronto = 1'b1;
            if (jogar) estado_next = preparacao;
         end
         fim_timeout: begin
            errou       = 1'b1;
            deu_timeout = 1'b1;
            pronto      = 1'b1;
            if (jogar) estado_next = preparacao;
         end
         default: begin
            db_estado   = 4'hF;
            estado_next = inicial;
         end
      endcase
   end

   // Timer runs only while dwelling in mostra or espera; any state change clears it
   always_comb begin
      timer_next = '0;
      if ((estado_next == estado) && ((estado == mostra) || (estado == espera)))
         timer_next = timer + 1'b1;
   end

endmodule

// File: tb/tb_jogo_seq_unidade_controle.sv
// Directed bench for the sequence-game control unit (TIMEOUT=8, MOSTRA_CICLOS=4, VIDAS=2).
module tb_jogo_seq_unidade_controle;

   logic       clock = 1'b0;
   logic       reset, jogar, jogada, igualE, igualL, fimL;
   logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, exibe;
   logic       acertou, errou, deu_timeout, pronto;
   logic [1:0] vidas;
   logic [3:0] db_estado;

   int vectors = 0;
   int fails   = 0;

   jogo_seq_unidade_controle #(
      .TIMEOUT(8), .MOSTRA_CICLOS(4), .VIDAS(2), .VW(2)
   ) dut (
      .clock(clock), .reset(reset), .jogar(jogar), .jogada(jogada),
      .igualE(igualE), .igualL(igualL), .fimL(fimL),
      .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
      .zeraR(zeraR), .registraR(registraR), .exibe(exibe),
      .acertou(acertou), .errou(errou), .deu_timeout(deu_timeout),
      .pronto(pronto), .vidas(vidas), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; jogar = 1'b0; jogada = 1'b0; igualE = 1'b0; igualL = 1'b0; fimL = 1'b0;
      tick(); tick();
      reset = 1'b0;
      vectors++; if (db_estado !== 4'h0) begin fails++; $display("FAIL reset_state: got %h want 0", db_estado); end
      vectors++; if ({zeraE, zeraL, zeraR} !== 3'b111) begin fails++; $display("FAIL reset_zera: got %b want 111", {zeraE, zeraL, zeraR}); end
      vectors++; if ({contaE, contaL, registraR, exibe, acertou, errou, deu_timeout, pronto} !== 8'h00) begin
         fails++; $display("FAIL reset_others: got %b want 00000000", {contaE, contaL, registraR, exibe, acertou, errou, deu_timeout, pronto}); end
      vectors++; if (vidas !== 2'd2) begin fails++; $display("FAIL reset_vidas: got %0d want 2", vidas); end
      tick();
      vectors++; if (db_estado !== 4'h0) begin fails++; $display("FAIL idle_hold: got %h want 0", db_estado); end
   endtask

   task automatic test_start();
      jogar = 1'b1; tick();
      vectors++; if (db_estado !== 4'h1) begin fails++; $display("FAIL start_prep: got %h want 1", db_estado); end
      jogar = 1'b0; igualL = 1'b1; tick();
      vectors++; if (db_estado !== 4'h7 || exibe !== 1'b1) begin fails++; $display("FAIL start_mostra1: got %h/%b want 7/1", db_estado, exibe); end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (db_estado !== 4'h7 || exibe !== 1'b1) begin fails++; $display("FAIL start_mostra%0d: got %h/%b want 7/1", i + 2, db_estado, exibe); end
      end
      tick();
      vectors++; if (db_estado !== 4'h9 || exibe !== 1'b0 || zeraE !== 1'b1) begin fails++; $display("FAIL start_fim_mostra: got %h/%b/%b want 9/0/1", db_estado, exibe, zeraE); end
      tick();
      vectors++; if (db_estado !== 4'h3 || vidas !== 2'd2) begin fails++; $display("FAIL start_espera: got %h/%0d want 3/2", db_estado, vidas); end
   endtask

   task automatic test_correct_round0();
      jogada = 1'b1; igualE = 1'b1; igualL = 1'b1; fimL = 1'b0; tick();
      vectors++; if (db_estado !== 4'h4 || registraR !== 1'b1) begin fails++; $display("FAIL r0_registra: got %h/%b want 4/1", db_estado, registraR); end
      jogada = 1'b0; tick();
      vectors++; if (db_estado !== 4'h5) begin fails++; $display("FAIL r0_comparacao: got %h want 5", db_estado); end
      tick();
      vectors++; if (db_estado !== 4'h2 || contaL !== 1'b1 || zeraE !== 1'b1) begin fails++; $display("FAIL r0_nova_seq: got %h/%b/%b want 2/1/1", db_estado, contaL, zeraE); end
      igualL = 1'b0; tick();
      for (int i = 0; i < 3; i++) tick();
      vectors++; if (db_estado !== 4'h7) begin fails++; $display("FAIL r1_mostra_e0: got %h want 7", db_estado); end
      tick();
      vectors++; if (db_estado !== 4'h8 || contaE !== 1'b1) begin fails++; $display("FAIL r1_mostra_prox: got %h/%b want 8/1", db_estado, contaE); end
      igualL = 1'b1; tick();
      vectors++; if (db_estado !== 4'h7) begin fails++; $display("FAIL r1_mostra_e1: got %h want 7", db_estado); end
      for (int i = 0; i < 3; i++) tick();
      tick();
      vectors++; if (db_estado !== 4'h9) begin fails++; $display("FAIL r1_fim_mostra: got %h want 9", db_estado); end
      tick();
      vectors++; if (db_estado !== 4'h3) begin fails++; $display("FAIL r1_espera: got %h want 3", db_estado); end
   endtask

   task automatic test_wrong();
      jogada = 1'b1; igualE = 1'b0; tick();
      jogada = 1'b0; tick(); tick();
      vectors++; if (db_estado !== 4'hB || zeraE !== 1'b1 || vidas !== 2'd2) begin fails++; $display("FAIL wrong_perde_vida: got %h/%b/%0d want B/1/2", db_estado, zeraE, vidas); end
      tick();
      vectors++; if (db_estado !== 4'h7 || vidas !== 2'd1) begin fails++; $display("FAIL wrong_replay: got %h/%0d want 7/1", db_estado, vidas); end
      for (int i = 0; i < 3; i++) tick();
      tick(); tick();
      vectors++; if (db_estado !== 4'h3) begin fails++; $display("FAIL wrong_espera: got %h want 3", db_estado); end
      jogada = 1'b1; tick();
      jogada = 1'b0; tick(); tick();
      vectors++; if (db_estado !== 4'hE) begin fails++; $display("FAIL wrong_fim_erro: got %h want E", db_estado); end
      vectors++; if ({errou, pronto, deu_timeout, acertou} !== 4'b1100) begin fails++; $display("FAIL wrong_flags: got %b want 1100", {errou, pronto, deu_timeout, acertou}); end
      vectors++; if (vidas !== 2'd1) begin fails++; $display("FAIL wrong_vidas: got %0d want 1", vidas); end
      tick();
      vectors++; if (db_estado !== 4'hE) begin fails++; $display("FAIL wrong_hold: got %h want E", db_estado); end
   endtask

   task automatic test_reset_fim_erro();
      jogar = 1'b1; reset = 1'b1; tick();
      vectors++; if (db_estado !== 4'h0 || vidas !== 2'd2) begin fails++; $display("FAIL rst_fim_erro: got %h/%0d want 0/2", db_estado, vidas); end
      reset = 1'b0; tick();
      vectors++; if (db_estado !== 4'h1) begin fails++; $display("FAIL rst_restart: got %h want 1", db_estado); end
      jogar = 1'b0; igualL = 1'b1; tick();
      for (int i = 0; i < 3; i++) tick();
      tick(); tick();
      vectors++; if (db_estado !== 4'h3) begin fails++; $display("FAIL rst_espera: got %h want 3", db_estado); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 7; i++) tick();
      vectors++; if (db_estado !== 4'h3) begin fails++; $display("FAIL to_before: got %h want 3", db_estado); end
      tick();
      vectors++; if (db_estado !== 4'hB) begin fails++; $display("FAIL to_perde_vida: got %h want B", db_estado); end
      tick();
      vectors++; if (vidas !== 2'd1) begin fails++; $display("FAIL to_vidas: got %0d want 1", vidas); end
      for (int i = 0; i < 3; i++) tick();
      tick(); tick();
      for (int i = 0; i < 8; i++) tick();
      vectors++; if (db_estado !== 4'hD) begin fails++; $display("FAIL to_fim_timeout: got %h want D", db_estado); end
      vectors++; if ({errou, deu_timeout, pronto, acertou} !== 4'b1110) begin fails++; $display("FAIL to_flags: got %b want 1110", {errou, deu_timeout, pronto, acertou}); end
      jogar = 1'b1; tick();
      jogar = 1'b0; tick();
      vectors++; if (db_estado !== 4'h7 || vidas !== 2'd2) begin fails++; $display("FAIL to_restart: got %h/%0d want 7/2", db_estado, vidas); end
      for (int i = 0; i < 3; i++) tick();
      tick(); tick();
   endtask

   task automatic test_jogada_at_timeout();
      for (int i = 0; i < 8; i++) tick();
      tick();
      for (int i = 0; i < 3; i++) tick();
      tick(); tick();
      for (int i = 0; i < 7; i++) tick();
      vectors++; if (db_estado !== 4'h3 || vidas !== 2'd1) begin fails++; $display("FAIL edge_espera: got %h/%0d want 3/1", db_estado, vidas); end
      jogada = 1'b1; igualE = 1'b1; igualL = 1'b1; fimL = 1'b1; tick();
      vectors++; if (db_estado !== 4'h4) begin fails++; $display("FAIL edge_registra: got %h want 4", db_estado); end
      jogada = 1'b0; tick(); tick();
      vectors++; if (db_estado !== 4'hA || {acertou, pronto, errou} !== 3'b110) begin fails++; $display("FAIL edge_fim_acerto: got %h/%b want A/110", db_estado, {acertou, pronto, errou}); end
      tick();
      vectors++; if (db_estado !== 4'hA || vidas !== 2'd1) begin fails++; $display("FAIL edge_hold: got %h/%0d want A/1", db_estado, vidas); end
   endtask

   task automatic test_back_to_back();
      jogar = 1'b1; tick();
      vectors++; if (db_estado !== 4'h1) begin fails++; $display("FAIL b2b_prep: got %h want 1", db_estado); end
      jogar = 1'b0; fimL = 1'b0; tick();
      vectors++; if (db_estado !== 4'h7 || vidas !== 2'd2) begin fails++; $display("FAIL b2b_reload: got %h/%0d want 7/2", db_estado, vidas); end
      for (int i = 0; i < 3; i++) tick();
      tick(); tick();
      for (int i = 0; i < 8; i++) tick();
      tick();
      vectors++; if (db_estado !== 4'h7 || vidas !== 2'd1) begin fails++; $display("FAIL b2b_replay: got %h/%0d want 7/1", db_estado, vidas); end
      reset = 1'b1; tick();
      reset = 1'b0;
      vectors++; if (db_estado !== 4'h0 || vidas !== 2'd2 || exibe !== 1'b0) begin fails++; $display("FAIL rst_mostra: got %h/%0d/%b want 0/2/0", db_estado, vidas, exibe); end
      vectors++; if ({zeraE, zeraL, zeraR} !== 3'b111) begin fails++; $display("FAIL rst_mostra_zera: got %b want 111", {zeraE, zeraL, zeraR}); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_correct_round0();
      test_wrong();
      test_reset_fim_erro();
      test_timeout();
      test_jogada_at_timeout();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
